// File: rtl/move_scheduler.sv
// move_scheduler
//   Input and gravity sequencer between the player buttons and the
//   piece-movement datapath. Debounces the four raw buttons, turns debounced
//   rising edges into requests, adds auto-repeat on left/right/down, runs a
//   level-dependent gravity timer, and arbitrates everything into at most one
//   registered single-cycle move command, held off while the datapath is busy.
//
// Ports
//   i_clk            clock, all state on the rising edge
//   i_rst            synchronous active-high reset
//   i_play_enable    high while a piece is in play
//   i_busy           datapath cannot accept a command this cycle
//   i_left/right/rotate/down   raw active-high buttons
//   i_level[3:0]     current level, selects gravity period
//   o_move_left/right/rotate/drop   one-cycle command pulses, mutually exclusive
//   o_drop_soft      qualifies o_move_drop: 1 = player soft drop, 0 = gravity only
module move_scheduler #(
   parameter int DB_CYCLES  = 250000,
   parameter int DAS_DELAY  = 5000000,
   parameter int ARR_PERIOD = 1250000,
   parameter int GRAV_BASE  = 12500000,
   parameter int GRAV_STEP  = 1000000,
   parameter int GRAV_MIN   = 1250000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_play_enable,
   input  logic       i_busy,
   input  logic       i_left,
   input  logic       i_right,
   input  logic       i_rotate,
   input  logic       i_down,
   input  logic [3:0] i_level,
   output logic       o_move_left,
   output logic       o_move_right,
   output logic       o_move_rotate,
   output logic       o_move_drop,
   output logic       o_drop_soft
);

   localparam int DB_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam int HOLD_W   = $clog2(DAS_DELAY + 1);
   localparam int ARR_W    = (ARR_PERIOD > 1) ? $clog2(ARR_PERIOD) : 1;
   localparam int GRAV_MAX = (GRAV_BASE > GRAV_MIN) ? GRAV_BASE : GRAV_MIN;
   localparam int GRAV_W   = (GRAV_MAX > 1) ? $clog2(GRAV_MAX) : 1;

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DAS_DELAY);
   localparam logic [ARR_W-1:0]  ARR_LAST  = ARR_W'(ARR_PERIOD - 1);
   localparam logic [31:0]       GRAV_BASE_U = 32'(GRAV_BASE);
   localparam logic [31:0]       GRAV_STEP_U = 32'(GRAV_STEP);
   localparam logic [31:0]       GRAV_MIN_U  = 32'(GRAV_MIN);

   // Button index within the 4-bit debounce vectors.
   localparam int B_LEFT  = 0;
   localparam int B_RIGHT = 1;
   localparam int B_ROT   = 2;
   localparam int B_DOWN  = 3;

   // Auto-repeat channel index: 0 = left, 1 = right, 2 = down.
   localparam int R_LEFT  = 0;
   localparam int R_RIGHT = 1;
   localparam int R_DOWN  = 2;

   // ---------------------------------------------------------------- state
   logic [DB_W-1:0]   db_cnt_q [4];
   logic [DB_W-1:0]   db_cnt_d [4];
   logic [3:0]        db_q, db_d;
   logic [3:0]        db_prev_q, db_prev_d;

   logic [HOLD_W-1:0] hold_q [3];
   logic [HOLD_W-1:0] hold_d [3];
   logic [ARR_W-1:0]  arr_q [3];
   logic [ARR_W-1:0]  arr_d [3];

   logic [GRAV_W-1:0] grav_q, grav_d;

   logic pend_rot_q,   pend_rot_d;
   logic pend_left_q,  pend_left_d;
   logic pend_right_q, pend_right_d;
   logic pend_soft_q,  pend_soft_d;
   logic pend_grav_q,  pend_grav_d;

   logic move_left_q,  move_left_d;
   logic move_right_q, move_right_d;
   logic move_rot_q,   move_rot_d;
   logic move_drop_q,  move_drop_d;
   logic drop_soft_q,  drop_soft_d;

   // ---------------------------------------------------------------- comb
   logic [3:0]        raw;
   logic [3:0]        edge_req;
   logic [2:0]        db_rpt;
   logic [2:0]        rpt_req;
   logic              req_left, req_right, req_rot, req_soft;
   logic [31:0]       lvl_red;
   logic [31:0]       grav_period;
   logic [GRAV_W-1:0] grav_last;
   logic              grav_expire;
   logic              out_any;
   logic              grant_ok;
   logic              gnt_rot, gnt_left, gnt_right, gnt_drop;

   assign raw    = {i_down, i_rotate, i_right, i_left};
   assign db_rpt = {db_q[B_DOWN], db_q[B_RIGHT], db_q[B_LEFT]};

   // Debounce: the counter only runs while raw disagrees with the debounced
   // value; any agreement, even for one cycle, restarts the count.
   always_comb begin
      db_d      = db_q;
      db_prev_d = db_q;
      for (int i = 0; i < 4; i++) begin
         db_cnt_d[i] = '0;
         if (raw[i] != db_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               db_d[i] = raw[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   // Edge requests are suppressed outside play; the previous-value register
   // keeps tracking so a button already held when play resumes does not fire.
   always_comb begin
      edge_req = '0;
      if (i_play_enable) begin
         edge_req = db_q & ~db_prev_q;
      end
   end

   // Auto-repeat: hold counts up to DAS_DELAY and parks there; from then on
   // the ARR counter cycles and a repeat is raised each time it is at zero.
   always_comb begin
      for (int j = 0; j < 3; j++) begin
         hold_d[j]  = '0;
         arr_d[j]   = '0;
         rpt_req[j] = 1'b0;
         if (i_play_enable && db_rpt[j]) begin
            if (hold_q[j] != HOLD_LAST) begin
               hold_d[j] = hold_q[j] + HOLD_W'(1);
            end else begin
               hold_d[j]  = hold_q[j];
               rpt_req[j] = (arr_q[j] == '0);
               arr_d[j]   = (arr_q[j] == ARR_LAST) ? '0 : arr_q[j] + ARR_W'(1);
            end
         end
      end
   end

   assign req_left  = edge_req[B_LEFT]  | rpt_req[R_LEFT];
   assign req_right = edge_req[B_RIGHT] | rpt_req[R_RIGHT];
   assign req_rot   = edge_req[B_ROT];
   assign req_soft  = edge_req[B_DOWN]  | rpt_req[R_DOWN];

   // Gravity period, clamped at GRAV_MIN without ever wrapping below zero.
   always_comb begin
      lvl_red     = 32'(i_level) * GRAV_STEP_U;
      grav_period = GRAV_MIN_U;
      if (lvl_red <= GRAV_BASE_U) begin
         if ((GRAV_BASE_U - lvl_red) >= GRAV_MIN_U) begin
            grav_period = GRAV_BASE_U - lvl_red;
         end
      end
      grav_last = GRAV_W'(grav_period - 32'd1);
   end

   // >= rather than == so that a level increase that shortens the period
   // below the current count expires immediately instead of wrapping.
   assign grav_expire = i_play_enable && (grav_q >= grav_last);

   always_comb begin
      grav_d = grav_q + GRAV_W'(1);
      if (!i_play_enable || req_soft || grav_expire) begin
         grav_d = '0;
      end
   end

   // Arbiter. The idle-cycle rule is enforced by refusing a grant while a
   // command pulse is currently on the outputs.
   assign out_any  = move_left_q | move_right_q | move_rot_q | move_drop_q;
   assign grant_ok = i_play_enable & ~i_busy & ~out_any;

   always_comb begin
      gnt_rot   = grant_ok & pend_rot_q;
      gnt_left  = grant_ok & ~pend_rot_q & pend_left_q;
      gnt_right = grant_ok & ~pend_rot_q & ~pend_left_q & pend_right_q;
      gnt_drop  = grant_ok & ~pend_rot_q & ~pend_left_q & ~pend_right_q
                  & (pend_soft_q | pend_grav_q);
   end

   // A new request on the same edge as a grant leaves the flag set.
   always_comb begin
      pend_rot_d   = i_play_enable & ((pend_rot_q   & ~gnt_rot)   | req_rot);
      pend_left_d  = i_play_enable & ((pend_left_q  & ~gnt_left)  | req_left);
      pend_right_d = i_play_enable & ((pend_right_q & ~gnt_right) | req_right);
      pend_soft_d  = i_play_enable & ((pend_soft_q  & ~gnt_drop)  | req_soft);
      pend_grav_d  = i_play_enable & ((pend_grav_q  & ~gnt_drop)  | grav_expire);
   end

   always_comb begin
      move_rot_d   = gnt_rot;
      move_left_d  = gnt_left;
      move_right_d = gnt_right;
      move_drop_d  = gnt_drop;
      drop_soft_d  = gnt_drop & pend_soft_q;
   end

   // ---------------------------------------------------------------- flops
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < 4; i++) begin
            db_cnt_q[i] <= '0;
         end
         db_q      <= '0;
         db_prev_q <= '0;
         for (int j = 0; j < 3; j++) begin
            hold_q[j] <= '0;
            arr_q[j]  <= '0;
         end
         grav_q       <= '0;
         pend_rot_q   <= 1'b0;
         pend_left_q  <= 1'b0;
         pend_right_q <= 1'b0;
         pend_soft_q  <= 1'b0;
         pend_grav_q  <= 1'b0;
         move_left_q  <= 1'b0;
         move_right_q <= 1'b0;
         move_rot_q   <= 1'b0;
         move_drop_q  <= 1'b0;
         drop_soft_q  <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            db_cnt_q[i] <= db_cnt_d[i];
         end
         db_q      <= db_d;
         db_prev_q <= db_prev_d;
         for (int j = 0; j < 3; j++) begin
            hold_q[j] <= hold_d[j];
            arr_q[j]  <= arr_d[j];
         end
         grav_q       <= grav_d;
         pend_rot_q   <= pend_rot_d;
         pend_left_q  <= pend_left_d;
         pend_right_q <= pend_right_d;
         pend_soft_q  <= pend_soft_d;
         pend_grav_q  <= pend_grav_d;
         move_left_q  <= move_left_d;
         move_right_q <= move_right_d;
         move_rot_q   <= move_rot_d;
         move_drop_q  <= move_drop_d;
         drop_soft_q  <= drop_soft_d;
      end
   end

   assign o_move_left   = move_left_q;
   assign o_move_right  = move_right_q;
   assign o_move_rotate = move_rot_q;
   assign o_move_drop   = move_drop_q;
   assign o_drop_soft   = drop_soft_q;

endmodule

// File: doc/move_scheduler.md
# move_scheduler

Input and gravity sequencer between the player buttons and the piece-movement datapath. Debounces the four raw buttons and detects their rising edges. Generates auto-repeat for left, right and down, and runs a level-dependent gravity timer. Arbitrates all requests into at most one single-cycle move command per cycle, and holds each command until the movement datapath can accept it.

## Interface
Parameters:
- DB_CYCLES, 250000: cycles a raw input must differ from its debounced value before the debounced value flips.
- DAS_DELAY, 5000000: cycles a direction must be held before auto-repeat starts.
- ARR_PERIOD, 1250000: auto-repeat interval, in cycles.
- GRAV_BASE, 12500000: gravity period at level 0, in cycles.
- GRAV_STEP, 1000000: period reduction per level.
- GRAV_MIN, 1250000: lower bound on the gravity period.

Ports:
- i_clk  in  1  single clock; all state updates on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_play_enable  in  1  high while a piece is in play.
- i_busy  in  1  datapath cannot accept a command this cycle.
- i_left, i_right, i_rotate, i_down  in  1 each  raw active-high buttons.
- i_level  in  4  current level, 0-15.
- o_move_left, o_move_right, o_move_rotate, o_move_drop  out  1 each  registered one-cycle command pulses; mutually exclusive.
- o_drop_soft  out  1  qualifies o_move_drop: 1 = player soft drop (possibly merged with gravity); 0 = gravity only.

## Operation
- Debounce, per button:
  - counter increments while raw != debounced, and clears when they are equal;
  - when the counter reaches DB_CYCLES-1, the debounced value flips and the counter clears.
- Edge: request = debounced & ~debounced_d1.
- Auto-repeat (left, right, down; rotate has none):
  - hold counter starts at the rising edge;
  - a repeat request is raised at hold = DAS_DELAY, then every ARR_PERIOD cycles while the debounced value stays high;
  - the counter clears on release.
- Gravity:
  - period P = GRAV_BASE - i_level*GRAV_STEP when that result is >= GRAV_MIN, otherwise P = GRAV_MIN; compute in 32 bits with no wrap;
  - timer counts 0..P-1; reaching P-1 sets pend_grav and restarts the timer at 0;
  - a soft-drop request also restarts the timer at 0;
  - i_level changes take effect on the next comparison.
- Pending flags: pend_rot, pend_left, pend_right, pend_soft, pend_grav.
  - A request sets its flag.
  - A request arriving while the flag is already set merges into that flag; no queueing.
- Arbiter, active when i_play_enable=1 and i_busy=0:
  - grant order: rotate > left > right > drop (pend_soft | pend_grav);
  - the granted flag(s) clear on the same edge the output pulse is registered;
  - a drop grant clears both pend_soft and pend_grav; o_drop_soft = pend_soft.
  - a request and a clear for the same flag in the same cycle: the set wins.
- i_play_enable = 0:
  - all pending flags clear; gravity timer held at 0;
  - hold counters are held at 0 and no requests are raised;
  - debouncers keep running.
- Reset: every output 0, every counter 0, every debounced value 0, every pending flag 0.

## Timing
- Debounced value rises DB_CYCLES cycles after the raw input rises; a glitch shorter than DB_CYCLES is ignored.
- Debounced rise at edge E: pending flag set at E+1, command pulse at E+2 when the datapath is free.
- Each i_busy=1 cycle delays the pulse by one cycle; the request is never lost.
- Command pulses are exactly one cycle wide, with at least one idle cycle between them.
- Gravity: first pulse P+1 cycles after i_play_enable rises, then one every P cycles when there is no contention.

## Test plan
All scenarios use DB_CYCLES=4, DAS_DELAY=20, ARR_PERIOD=5, GRAV_BASE=100, GRAV_STEP=10, GRAV_MIN=30.
- Reset, then i_play_enable=1 at level 0 -> o_move_drop pulses with o_drop_soft=0, first at cycle 101, then every 100 cycles; all outputs 0 during reset.
- i_level=9 (100-90 < 30) -> gravity period 30; i_level=5 -> period 50.
- i_left held 60 cycles -> one edge pulse, a repeat at hold 20, then repeats every 5 cycles; stops on release; a 3-cycle glitch yields no pulse.
- i_rotate and i_right rise in the same cycle -> o_move_rotate, then o_move_right on the following free cycle; rotate held produces no repeat.
- i_busy=1 for 10 cycles with pend_left and pend_grav set -> no pulses; after release, o_move_left, then o_move_drop; nothing lost or duplicated.
- Soft drop coinciding with a gravity expiry -> a single o_move_drop with o_drop_soft=1, gravity timer restarts.
- i_play_enable dropped with pending flags set -> no pulses; flags clear.
- Reset asserted mid-hold of i_down -> outputs 0; after release of reset, the button is re-debounced from 0.
